// File: rtl/isr_pkg.sv
// Shared constants and types for the integer-square-root sequencing controller.
// Packet format: [47:45] index (0 = idle beat), [44] last flag, [43:0] payload.
package isr_pkg;

  localparam int unsigned DATA_WID    = 256;  // radicand width
  localparam int unsigned DATAIN      = 48;   // packet width
  localparam int unsigned ROOT_WID    = 128;  // root width
  localparam int unsigned TIMEOUT_DEF = 1024; // default core timeout in cycles
  localparam int unsigned TMO_W_DEF   = $clog2(TIMEOUT_DEF);

  // Header field positions
  localparam int unsigned IDX_MSB   = 47;
  localparam int unsigned IDX_LSB   = 45;
  localparam int unsigned LAST_BIT  = 44;
  localparam int unsigned PAYLOAD_W = 44;

  // Inbound framing: slots 1..5 carry full payloads, packet 6 carries payload[43:8]
  localparam int unsigned NUM_SLOTS = 5;
  localparam int unsigned LAST_IDX  = 6;
  localparam int unsigned TAIL_W    = 36;

  // Outbound framing
  localparam int unsigned OUT_BEATS = 3;

  typedef enum logic [1:0] {StIdle, StRun, StSend} state_e;

  // LSB of slot 1..5 inside the radicand: 212, 168, 124, 80, 36
  function automatic int unsigned slot_lsb(input int unsigned slot);
    return DATA_WID - PAYLOAD_W * slot;
  endfunction

endpackage

// File: rtl/isr_pkt_ser.sv
// Three-beat output serialiser for the 128-bit root.
// Ports: clk/rst_n clock and async active-low reset; load_i captures root_i and starts
// beat 1; rdy_i downstream ready; data_o/vld_o outbound beat; sent_o pulses when the
// final beat is accepted.
module isr_pkt_ser
  import isr_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [ROOT_WID-1:0] root_i,
  input  logic                rdy_i,
  output logic [DATAIN-1:0]   data_o,
  output logic                vld_o,
  output logic                sent_o
);

  logic [ROOT_WID-1:0] res_q, res_d;
  logic [1:0]          beat_q, beat_d;
  logic                vld_q, vld_d;
  logic                accept;

  assign accept = vld_q & rdy_i;
  assign sent_o = accept && (beat_q == 2'(OUT_BEATS));
  assign vld_o  = vld_q;

  always_comb begin
    res_d  = res_q;
    beat_d = beat_q;
    vld_d  = vld_q;
    if (load_i) begin
      res_d  = root_i;
      beat_d = 2'd1;
      vld_d  = 1'b1;
    end else if (accept) begin
      if (beat_q == 2'(OUT_BEATS)) begin
        beat_d = 2'd0;
        vld_d  = 1'b0;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end
  end

  // Beat content follows beat_q only, so it holds steady while rdy_i is low.
  always_comb begin
    data_o = '0;
    case (beat_q)
      2'd1:    data_o = {3'd1, 1'b0, res_q[ROOT_WID-1 -: PAYLOAD_W]};
      2'd2:    data_o = {3'd2, 1'b0, res_q[ROOT_WID-PAYLOAD_W-1 -: PAYLOAD_W]};
      2'd3:    data_o = {3'd3, 1'b1, res_q[ROOT_WID-2*PAYLOAD_W-1:0], 4'b0};
      default: data_o = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      beat_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      beat_q <= beat_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/isr_ctrl.sv
// Sequencing controller for the integer-square-root datapath.
// Collects 48-bit packets into a 256-bit radicand, buffers one completed operand,
// launches the sqrt core with a start/done handshake, times out a hung core, and
// serialises the 128-bit root as three 48-bit valid/ready beats.
// Ports: clk, rst_n (async active-low); datain inbound packets; sq_a/sq_start to core;
// sq_done/sq_root from core; dataout/dout_vld/dout_rdy outbound stream; busy status;
// err_seq/err_ovf/err_tmo one-cycle error pulses.
module isr_ctrl
  import isr_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATAIN-1:0]   datain,
  output logic [DATA_WID-1:0] sq_a,
  output logic                sq_start,
  input  logic                sq_done,
  input  logic [ROOT_WID-1:0] sq_root,
  output logic [DATAIN-1:0]   dataout,
  output logic                dout_vld,
  input  logic                dout_rdy,
  output logic                busy,
  output logic                err_seq,
  output logic                err_ovf,
  output logic                err_tmo
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]           pkt_idx;
  logic                 pkt_last;
  logic [PAYLOAD_W-1:0] pkt_pay;

  assign pkt_idx  = datain[IDX_MSB:IDX_LSB];
  assign pkt_last = datain[LAST_BIT];
  assign pkt_pay  = datain[PAYLOAD_W-1:0];

  logic [2:0]          exp_idx_q, exp_idx_d;
  logic [DATA_WID-1:0] asm_q, asm_d;
  logic [DATA_WID-1:0] hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  state_e              state_q, state_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [DATA_WID-1:0] sq_a_q, sq_a_d;
  logic                sq_start_q, sq_start_d;
  logic                err_seq_q, err_ovf_q, err_tmo_q;

  logic                seq_err, ovf_err, tmo_err;
  logic                op_done, store, launch;
  logic [DATA_WID-1:0] operand;
  logic                ser_load, ser_sent;

  // Collector
  always_comb begin
    exp_idx_d = exp_idx_q;
    asm_d     = asm_q;
    seq_err   = 1'b0;
    op_done   = 1'b0;
    store     = 1'b0;
    operand   = {asm_q[DATA_WID-1:TAIL_W], pkt_pay[PAYLOAD_W-1 -: TAIL_W]};
    if (pkt_idx != 3'd0) begin
      // exp_idx only ranges 1..6, so a match below 6 is a middle slot
      if (pkt_idx == exp_idx_q && pkt_idx != 3'(LAST_IDX) && !pkt_last) begin
        store     = 1'b1;
        exp_idx_d = exp_idx_q + 3'd1;
      end else if (pkt_idx == 3'(LAST_IDX) && exp_idx_q == 3'(LAST_IDX) && pkt_last) begin
        op_done   = 1'b1;
        asm_d     = '0;
        exp_idx_d = 3'd1;
      end else begin
        seq_err   = 1'b1;
        asm_d     = '0;
        exp_idx_d = 3'd1;
        // A stray first packet still opens a fresh frame
        if (pkt_idx == 3'd1 && !pkt_last) begin
          store     = 1'b1;
          exp_idx_d = 3'd2;
        end
      end
    end
    if (store) begin
      for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
        if (pkt_idx == 3'(k)) asm_d[slot_lsb(k) +: PAYLOAD_W] = pkt_pay;
      end
    end
  end

  // One-deep operand buffer; a launch frees the slot in the same cycle
  assign launch = (state_q == StIdle) && hold_vld_q;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    ovf_err    = 1'b0;
    if (launch) hold_vld_d = 1'b0;
    if (op_done) begin
      if (hold_vld_q && !launch) begin
        ovf_err = 1'b1;
      end else begin
        hold_d     = operand;
        hold_vld_d = 1'b1;
      end
    end
  end

  // Control FSM
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    sq_a_d     = sq_a_q;
    sq_start_d = 1'b0;
    tmo_err    = 1'b0;
    ser_load   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hold_vld_q) begin
          sq_a_d     = hold_q;
          sq_start_d = 1'b1;
          tmo_d      = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        tmo_d = tmo_q + 1'b1;
        // sq_start_q marks the launch cycle, where a done is not yet meaningful
        if (sq_done && !sq_start_q) begin
          ser_load = 1'b1;
          state_d  = StSend;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          tmo_err = 1'b1;
          state_d = StIdle;
        end
      end
      StSend: begin
        if (ser_sent) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_idx_q  <= 3'd1;
      asm_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      state_q    <= StIdle;
      tmo_q      <= '0;
      sq_a_q     <= '0;
      sq_start_q <= 1'b0;
      err_seq_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      exp_idx_q  <= exp_idx_d;
      asm_q      <= asm_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      sq_a_q     <= sq_a_d;
      sq_start_q <= sq_start_d;
      err_seq_q  <= seq_err;
      err_ovf_q  <= ovf_err;
      err_tmo_q  <= tmo_err;
    end
  end

  isr_pkt_ser u_ser (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ser_load),
    .root_i (sq_root),
    .rdy_i  (dout_rdy),
    .data_o (dataout),
    .vld_o  (dout_vld),
    .sent_o (ser_sent)
  );

  assign sq_a     = sq_a_q;
  assign sq_start = sq_start_q;
  assign busy     = (state_q != StIdle) || hold_vld_q;
  assign err_seq  = err_seq_q;
  assign err_ovf  = err_ovf_q;
  assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_isr_ctrl.sv
module tb_isr_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [47:0]  datain;
  logic [255:0] sq_a;
  logic         sq_start;
  logic         sq_done;
  logic [127:0] sq_root;
  logic [47:0]  dataout;
  logic         dout_vld;
  logic         dout_rdy;
  logic         busy, err_seq, err_ovf, err_tmo;

  always #5 clk = ~clk;

  isr_ctrl #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .datain   (datain),
    .sq_a     (sq_a),
    .sq_start (sq_start),
    .sq_done  (sq_done),
    .sq_root  (sq_root),
    .dataout  (dataout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .err_seq  (err_seq),
    .err_ovf  (err_ovf),
    .err_tmo  (err_tmo)
  );

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_beats = 0, n_seq = 0, n_ovf = 0, n_tmo = 0;
  int cyc = 0;

  logic [255:0] exp_a_q[$];
  logic [47:0]  exp_beat_q[$];
  logic [43:0]  fr[1:6];

  typedef struct {
    logic [2:0]  idx;
    logic        last;
    logic [43:0] pay;
    logic        seq;
    logic        cmpl;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] beat(input logic [127:0] r, input int k);
    if (k == 1) return {3'd1, 1'b0, r[127:84]};
    if (k == 2) return {3'd2, 1'b0, r[83:40]};
    return {3'd3, 1'b1, r[39:0], 4'h0};
  endfunction

  function automatic logic [255:0] build_op();
    return {fr[1], fr[2], fr[3], fr[4], fr[5], fr[6][43:8]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: pop expectations as the DUT produces launches and beats
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (err_seq) n_seq++;
      if (err_ovf) n_ovf++;
      if (err_tmo) n_tmo++;
      if (sq_start) begin
        n_start++;
        if (exp_a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sq_start: got sq_start=1 expected 0");
        end else check("sq_a", sq_a, exp_a_q.pop_front());
      end
      if (dout_vld && dout_rdy) begin
        n_beats++;
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h expected none", dataout);
        end else check("dataout", {208'd0, dataout}, {208'd0, exp_beat_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [2:0] idx, input logic last, input logic [43:0] pay);
    datain = {idx, last, pay};
    tick(1);
    datain = '0;
  endtask

  task automatic send_frame(input bit push);
    for (int i = 1; i <= 6; i++) send_pkt(3'(i), (i == 6), fr[i]);
    if (push) exp_a_q.push_back(build_op());
  endtask

  task automatic rand_frame();
    for (int i = 1; i <= 6; i++) fr[i] = {12'(i), 32'($urandom)};
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (sq_start !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check("sq_start_seen", {255'd0, sq_start}, 256'd1);
  endtask

  task automatic core_run(input int dly, input logic [127:0] root);
    tick(dly);
    sq_done = 1'b1;
    sq_root = root;
    for (int k = 1; k <= 3; k++) exp_beat_q.push_back(beat(root, k));
    tick(1);
    sq_done = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_beat_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("beats_drained", 256'(exp_beat_q.size()), 256'd0);
  endtask

  task automatic add(input logic [2:0] idx, input logic last, input logic seq,
                     input logic cmpl);
    vec_t v;
    v.idx  = idx;
    v.last = last;
    v.pay  = {12'(tbl.size()), 32'($urandom)};
    v.seq  = seq;
    v.cmpl = cmpl;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, c0, s0, o0, t0;
    logic [127:0] r;
    rst_n = 1'b0; datain = '0; sq_done = 1'b0; sq_root = '0; dout_rdy = 1'b1;
    tick(3);
    check("rst_sq_a", sq_a, 256'd0);
    check("rst_outs", {250'd0, sq_start, dout_vld, busy, err_seq, err_ovf, err_tmo}, 256'd0);
    check("rst_dataout", {208'd0, dataout}, 256'd0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: basic frame, launch latency, three beats
    for (int i = 1; i <= 6; i++) fr[i] = 44'h1;
    send_frame(1);
    check("start_not_early", {255'd0, sq_start}, 256'd0);
    check("busy_held", {255'd0, busy}, 256'd1);
    tick(1);
    check("start_latency", {255'd0, sq_start}, 256'd1);
    b0 = n_beats;
    core_run(10, 128'h1);
    drain(20);
    tick(2);
    check("t1_beats", 256'(n_beats - b0), 256'd3);
    check("t1_idle", {254'd0, busy, dout_vld}, 256'd0);

    // Test 2: table-driven collector vectors
    add(3'd0, 0, 0, 0); add(3'd1, 0, 0, 0); add(3'd2, 0, 0, 0); add(3'd4, 0, 1, 0);
    add(3'd1, 0, 0, 0); add(3'd2, 0, 0, 0); add(3'd3, 1, 1, 0); add(3'd7, 0, 1, 0);
    add(3'd1, 0, 0, 0); add(3'd2, 0, 0, 0); add(3'd1, 0, 1, 0); add(3'd2, 0, 0, 0);
    add(3'd3, 0, 0, 0); add(3'd4, 0, 0, 0); add(3'd5, 0, 0, 0); add(3'd6, 0, 1, 0);
    add(3'd6, 1, 1, 0); add(3'd1, 0, 0, 0); add(3'd2, 0, 0, 0); add(3'd3, 0, 0, 0);
    add(3'd0, 0, 0, 0); add(3'd4, 0, 0, 0); add(3'd5, 0, 0, 0); add(3'd6, 1, 0, 1);
    s0 = n_start;
    foreach (tbl[i]) begin
      if (tbl[i].idx >= 3'd1 && tbl[i].idx <= 3'd5 && !tbl[i].last) fr[tbl[i].idx] = tbl[i].pay;
      if (tbl[i].cmpl) begin
        fr[6] = tbl[i].pay;
        exp_a_q.push_back(build_op());
      end
      send_pkt(tbl[i].idx, tbl[i].last, tbl[i].pay);
      check($sformatf("tbl%0d_err_seq", i), {255'd0, err_seq}, {255'd0, tbl[i].seq});
      if (!tbl[i].cmpl) check($sformatf("tbl%0d_no_start", i), 256'(n_start - s0), 256'd0);
    end
    wait_start(5);
    r = {$urandom, $urandom, $urandom, $urandom};
    core_run(3, r);
    drain(20);
    tick(2);

    // Test 3: overflow while core busy
    o0 = n_ovf;
    rand_frame(); send_frame(1);
    rand_frame(); send_frame(1);
    check("t3_no_ovf_yet", 256'(n_ovf - o0), 256'd0);
    rand_frame(); send_frame(0);
    check("t3_err_ovf", {255'd0, err_ovf}, 256'd1);
    core_run(0, 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe);
    drain(20);
    wait_start(20);
    core_run(4, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100);
    drain(20);
    tick(2);
    check("t3_ovf_count", 256'(n_ovf - o0), 256'd1);

    // Test 4: back-pressure on beat 2
    rand_frame(); send_frame(1);
    wait_start(5);
    r = {$urandom, $urandom, $urandom, $urandom};
    b0 = n_beats;
    dout_rdy = 1'b0;
    core_run(3, r);
    check("t4_beat1", {207'd0, dout_vld, dataout}, {207'd0, 1'b1, beat(r, 1)});
    dout_rdy = 1'b1;
    tick(1);
    dout_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold%0d", i), {207'd0, dout_vld, dataout}, {207'd0, 1'b1, beat(r, 2)});
      tick(1);
    end
    dout_rdy = 1'b1;
    drain(10);
    tick(2);
    check("t4_beats", 256'(n_beats - b0), 256'd3);

    // Test 5: core timeout
    t0 = n_tmo;
    rand_frame(); send_frame(1);
    wait_start(5);
    c0 = cyc;
    begin
      int n = 0;
      while (err_tmo !== 1'b1 && n < 40) begin
        tick(1);
        n++;
      end
    end
    check("t5_tmo_delay", 256'(cyc - c0), 256'd16);
    check("t5_busy_drop", {254'd0, busy, dout_vld}, 256'd0);
    tick(2);
    check("t5_tmo_count", 256'(n_tmo - t0), 256'd1);

    // Test 6: async reset during beat 2
    rand_frame(); send_frame(1);
    wait_start(5);
    r = {$urandom, $urandom, $urandom, $urandom};
    dout_rdy = 1'b0;
    core_run(2, r);
    dout_rdy = 1'b1;
    tick(1);
    dout_rdy = 1'b0;
    check("t6_beat2", {208'd0, dataout}, {208'd0, beat(r, 2)});
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_outs", {253'd0, dout_vld, busy, sq_start}, 256'd0);
    check("t6_rst_data", {208'd0, dataout}, 256'd0);
    check("t6_rst_sq_a", sq_a, 256'd0);
    exp_beat_q.delete();
    @(posedge clk); #1;
    tick(1);
    s0 = n_seq; o0 = n_ovf; t0 = n_tmo; b0 = n_beats;
    rst_n = 1'b1;
    dout_rdy = 1'b1;
    tick(3);
    check("t6_no_pulses", 256'((n_seq - s0) + (n_ovf - o0) + (n_tmo - t0)), 256'd0);
    rand_frame(); send_frame(1);
    wait_start(5);
    core_run(5, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);
    drain(20);
    tick(3);
    check("t6_beats", 256'(n_beats - b0), 256'd3);
    check("t6_final_idle", {254'd0, busy, dout_vld}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isr_ctrl.md
Name: isr_ctrl

Overview:
Sequencing controller for the integer-square-root datapath. It accepts the 48-bit packet stream, checks packet order, and assembles the 256-bit radicand. It launches the sqrt core and times out a hung core. It serialises the 128-bit root back out as 48-bit packets with a valid/ready handshake. It replaces the free-running collect/enable path with an explicit start/done handshake, a one-deep operand buffer and error reporting.

Parameters:
DATA_WID, 256, radicand width
DATAIN, 48, packet width (header [47:45] index, [44] last flag, [43:0] payload)
ROOT_WID, 128, root width
TIMEOUT, 1024, max cycles from sq_start to sq_done

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
datain  in  DATAIN  inbound packet; index 0 = idle beat
sq_a  out  DATA_WID  radicand to core, stable while state RUN
sq_start  out  1  one-cycle launch pulse
sq_done  in  1  one-cycle completion pulse from core
sq_root  in  ROOT_WID  root, valid with sq_done
dataout  out  DATAIN  outbound result packet
dout_vld  out  1  dataout valid
dout_rdy  in  1  downstream accepts beat
busy  out  1  state != IDLE or hold_vld
err_seq  out  1  one-cycle pulse: packet order/last-flag violation
err_ovf  out  1  one-cycle pulse: completed operand dropped, buffer full
err_tmo  out  1  one-cycle pulse: core timeout

Behaviour:
- Reset (async, rst_n=0): all outputs 0, exp_idx=1, hold_vld=0, state IDLE, assembly and result registers cleared. A reset mid-operation abandons the frame; no pulses are emitted on release.
- Collector: samples datain every clk. Index 0 is ignored.
  - idx==exp_idx, idx 1..5, last=0: store payload at slot (1:[255:212], 2:[211:168], 3:[167:124], 4:[123:80], 5:[79:36]); exp_idx++.
  - idx==6==exp_idx, last=1: store payload[43:8] to [35:0]; operand complete; exp_idx<=1.
  - Any other nonzero idx, or last=1 on idx 1..5, or idx 6 with last=0: err_seq pulse, assembly discarded, exp_idx<=1. If the offending idx==1 with last=0, it is accepted as the first packet of a new frame (exp_idx<=2).
- Buffer: on operand complete, hold<=operand and hold_vld<=1 at the same edge.
  - If hold_vld is already 1 and not being launched that cycle: err_ovf pulse; new operand dropped; hold unchanged.
  - Launch and completion in the same cycle: the hold register takes the new operand and hold_vld stays 1.
- Control FSM states IDLE, RUN, SEND:
  - IDLE: if hold_vld, then sq_a<=hold, sq_start=1 for exactly one cycle, hold_vld<=0, tmo_cnt<=0, go RUN. Minimum latency: sq_start is high in the 2nd cycle after the edge that samples packet 6.
  - RUN: tmo_cnt increments each cycle.
    - sq_done: res<=sq_root, beat<=1, go SEND.
    - tmo_cnt==TIMEOUT-1 with no sq_done: err_tmo pulse, go IDLE, no output.
    - sq_done in the launch cycle is ignored.
  - SEND: dout_vld=1. Beat 1 = {3'd1,1'b0,res[127:84]}; beat 2 = {3'd2,1'b0,res[83:40]}; beat 3 = {3'd3,1'b1,res[39:0],4'b0}.
    - A beat advances only on dout_vld&dout_rdy.
    - dataout is held stable while dout_rdy=0.
    - After beat 3 is accepted: dout_vld=0, go IDLE. A buffered operand launches on the next cycle.
- Collection runs independently of FSM state. Inbound packets are never back-pressured.
- Error pulses are mutually independent and may coincide.

Decomposition:
- Package isr_pkg:
  - header field positions (IDX_MSB=47, IDX_LSB=45, LAST_BIT=44, PAYLOAD_W=44)
  - slot bit-range constants
  - out-beat count 3
  - state enum {IDLE, RUN, SEND}
  - TIMEOUT counter width $clog2(TIMEOUT)
- One sub-module isr_pkt_ser: 3-beat output serialiser (res load, beat counter, valid/ready).
- Collector, buffer and FSM stay in isr_ctrl.

Test Plan:
- Frame idx 1..6 (last on 6), payloads 44'h0..01 each, sq_done after 10 cycles with root=128'h1: sq_start is 2 cycles after packet 6; sq_a matches the assembly map; 3 beats, final {3,1,40'h1,4'h0}.
- Packets 1,2,4: err_seq pulse at idx 4, no sq_start. A following clean 1..6 frame launches normally.
- Two complete frames while the core is busy (sq_done withheld): 1st runs, 2nd held; a 3rd completing frame gives an err_ovf pulse. After done + send, the 2nd launches.
- dout_rdy=0 for 5 cycles on beat 2: dataout/dout_vld stable; advances on the first dout_rdy=1; 3 accepted beats total.
- TIMEOUT=16, sq_done never asserted: err_tmo exactly 16 cycles after sq_start; FSM back to IDLE; busy drops if hold empty.
- rst_n low during SEND beat 2: outputs 0 immediately (async); after release a new frame is processed cleanly with no stale beats.
